// File: rtl/response_router_l2.sv
// Response router for one master port of the L2 crossbar.
// Every granted request is tracked through the fixed-latency memory pipeline
// together with the cut index it addressed. When the request reaches the tail,
// that cut's read data is steered back to the master with a valid strobe.
// An optional output register adds one cycle of latency.
module response_router_l2 #(
  parameter int N_SLAVE     = 8,
  parameter int ROUT_WIDTH  = $clog2(N_SLAVE),
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1,
  parameter int OUT_REG     = 0,
  parameter int CNT_WIDTH   = $clog2(MEM_LATENCY + OUT_REG + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          data_req_i,
  input  logic                          data_gnt_i,
  input  logic [ROUT_WIDTH-1:0]         routing_addr_i,
  input  logic [N_SLAVE*DATA_WIDTH-1:0] data_r_rdata_i,
  output logic                          data_r_valid_o,
  output logic [DATA_WIDTH-1:0]         data_r_rdata_o,
  output logic                          route_err_o,
  output logic [CNT_WIDTH-1:0]          inflight_o
);

  // One extra bit so the cut count itself is representable next to the index.
  localparam logic [ROUT_WIDTH:0] N_SLAVE_W = (ROUT_WIDTH + 1)'(N_SLAVE);

  logic                  accept;
  logic [MEM_LATENCY-1:0] stg_vld;
  logic [ROUT_WIDTH-1:0] stg_idx [MEM_LATENCY];
  logic                  tail_vld;
  logic [ROUT_WIDTH-1:0] tail_idx;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  sel_err;
  logic                  emit;
  logic [CNT_WIDTH-1:0]  inflight_q;

  assign accept   = data_req_i & data_gnt_i;
  assign tail_vld = stg_vld[MEM_LATENCY-1];
  assign tail_idx = stg_idx[MEM_LATENCY-1];

  // Tracking shift register: no stall, the memory has a fixed latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld <= '0;
      for (int k = 0; k < MEM_LATENCY; k++) begin
        stg_idx[k] <= '0;
      end
    end else begin
      stg_vld[0] <= accept;
      stg_idx[0] <= routing_addr_i;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        stg_vld[k] <= stg_vld[k-1];
        stg_idx[k] <= stg_idx[k-1];
      end
    end
  end

  // AND-OR cut select at the tail; indices beyond the last cut return zero
  // and flag a routing error instead of reading past the bus.
  always_comb begin
    sel_rdata = '0;
    sel_err   = 1'b0;
    if (tail_vld) begin
      if ({1'b0, tail_idx} < N_SLAVE_W) begin
        for (int k = 0; k < N_SLAVE; k++) begin
          if (tail_idx == ROUT_WIDTH'(k)) begin
            sel_rdata = data_r_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end else begin
        sel_err = 1'b1;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  valid_q;
      logic [DATA_WIDTH-1:0] rdata_q;
      logic                  err_q;

      // Retime the selected response by one cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          rdata_q <= '0;
          err_q   <= 1'b0;
        end else begin
          valid_q <= tail_vld;
          rdata_q <= sel_rdata;
          err_q   <= sel_err;
        end
      end

      assign data_r_valid_o = valid_q;
      assign data_r_rdata_o = rdata_q;
      assign route_err_o    = err_q;
    end else begin : g_out_comb
      assign data_r_valid_o = tail_vld;
      assign data_r_rdata_o = sel_rdata;
      assign route_err_o    = sel_err;
    end
  endgenerate

  // A response leaves the block when valid is presented at the output.
  assign emit = data_r_valid_o;

  // In-flight count: accept and emit in the same cycle cancel out. The
  // pipeline depth bounds the count, so it cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      case ({accept, emit})
        2'b10:   inflight_q <= inflight_q + CNT_WIDTH'(1);
        2'b01:   inflight_q <= inflight_q - CNT_WIDTH'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign inflight_o = inflight_q;

endmodule
